serial_sub: RTL and testbench

- Bit-serial unsigned subtractor computing diff = a - b, LSB first, one bit per clock.
- Built around a single-bit borrow-propagating subtractor cell; a borrow register chains the bit positions across cycles.
- Serves area-constrained datapaths that can trade latency for one cell instead of W cells.
- Start/ready/done handshake to the controlling FSM upstream; result bus to the consumer downstream.

---
 rtl/serial_sub_pkg.sv | 22 ++
 rtl/serial_sub_full_sub_bit.sv | 19 +
 rtl/serial_sub.sv | 145 ++++++++++++++
 tb/tb_serial_sub.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding, default
// width and the single-bit borrow-propagating subtract function.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int SUB_W_DEFAULT = 8;

    // Returns {borrow_out, difference} for x - y - bin.
    function automatic logic [1:0] full_sub(input logic x, input logic y, input logic bin);
        logic d_v;
        logic bo_v;
        d_v  = x ^ y ^ bin;
        bo_v = (~x & y) | (~(x ^ y) & bin);
        return {bo_v, d_v};
    endfunction

endpackage

// File: rtl/serial_sub_full_sub_bit.sv
// One-bit borrow-propagating subtractor cell; the only arithmetic in the
// serial subtractor, reused across all bit positions over time.
module full_sub_bit
    import serial_sub_pkg::*;
(
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bo
);

    logic [1:0] res_s;

    assign res_s = full_sub(x, y, bin);
    assign d     = res_s[0];
    assign bo    = res_s[1];

endmodule

// File: rtl/serial_sub.sv
// Bit-serial unsigned subtractor diff = a - b, LSB first, one bit per clock,
// with a start/ready/done handshake and registered result flags.
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int W = SUB_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         ready,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] diff,
    output logic         borrow_out,
    output logic         zero
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [1:0]    S_IDLE   = IDLE;
    localparam logic [1:0]    S_RUN    = RUN;
    localparam logic [1:0]    S_DONE   = DONE;

    logic [1:0]    state_r;
    logic [1:0]    state_nxt_s;
    logic [W-1:0]  sa_r;
    logic [W-1:0]  sb_r;
    logic [W-1:0]  diff_r;
    logic [W-1:0]  diff_nxt_s;
    logic          br_r;
    logic [CW-1:0] cnt_r;
    logic          ready_r;
    logic          busy_r;
    logic          done_r;
    logic          borrow_out_r;
    logic          zero_r;
    logic          d_s;
    logic          bo_s;
    logic          load_s;
    logic          run_s;
    logic          last_bit_s;
    logic          fin_s;

    full_sub_bit u_cell (
        .x   (sa_r[0]),
        .y   (sb_r[0]),
        .bin (br_r),
        .d   (d_s),
        .bo  (bo_s)
    );

    assign load_s     = (state_r == S_IDLE) && start;
    assign run_s      = (state_r == S_RUN);
    assign last_bit_s = (cnt_r == CNT_LAST);
    assign fin_s      = run_s && last_bit_s;
    assign diff_nxt_s = {d_s, diff_r[W-1:1]};

    // Next-state decode; DONE always lasts exactly one cycle.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_nxt_s = S_RUN;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_RUN: begin
                if (last_bit_s) begin
                    state_nxt_s = S_DONE;
                end else begin
                    state_nxt_s = S_RUN;
                end
            end
            S_DONE:  state_nxt_s = S_IDLE;
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // State register and handshake flags, registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            ready_r <= (state_nxt_s == S_IDLE);
            busy_r  <= (state_nxt_s == S_RUN);
            done_r  <= (state_nxt_s == S_DONE);
        end
    end

    // Operand shift registers, borrow chain and bit counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            sa_r  <= {W{1'b0}};
            sb_r  <= {W{1'b0}};
            br_r  <= 1'b0;
            cnt_r <= {CW{1'b0}};
        end else if (load_s) begin
            sa_r  <= a;
            sb_r  <= b;
            br_r  <= 1'b0;
            cnt_r <= {CW{1'b0}};
        end else if (run_s) begin
            sa_r <= {1'b0, sa_r[W-1:1]};
            sb_r <= {1'b0, sb_r[W-1:1]};
            br_r <= bo_s;
            // Hold on the last bit so the counter cannot wrap when W is a power of two.
            if (!last_bit_s) begin
                cnt_r <= cnt_r + CNT_ONE;
            end
        end
    end

    // Result register fills MSB-first from the cell; flags latch on the final bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            diff_r       <= {W{1'b0}};
            borrow_out_r <= 1'b0;
            zero_r       <= 1'b0;
        end else if (run_s) begin
            diff_r <= diff_nxt_s;
            if (fin_s) begin
                borrow_out_r <= bo_s;
                zero_r       <= (diff_nxt_s == {W{1'b0}});
            end
        end
    end

    assign ready      = ready_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign diff       = diff_r;
    assign borrow_out = borrow_out_r;
    assign zero       = zero_r;

endmodule

// File: tb/tb_serial_sub.sv
// Directed self-checking bench for serial_sub: W=8 vectors, handshake corner
// cases, mid-run reset, and an exhaustive W=4 sweep.
module tb_serial_sub;

    logic       clk = 1'b0;
    logic       rst;
    logic       start8, start4;
    logic [7:0] a8, b8, diff8;
    logic [3:0] a4, b4, diff4;
    logic       ready8, busy8, done8, bout8, zero8;
    logic       ready4, busy4, done4, bout4, zero4;
    int         total = 0;
    int         bad   = 0;

    always #5 clk = ~clk;

    serial_sub #(.W(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .ready(ready8), .busy(busy8), .done(done8),
        .diff(diff8), .borrow_out(bout8), .zero(zero8)
    );

    serial_sub #(.W(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
        .ready(ready4), .busy(busy4), .done(done4),
        .diff(diff4), .borrow_out(bout4), .zero(zero4)
    );

    // Waits for ready, issues one start, returns result and edges from start to done.
    task automatic run_op8(input logic [7:0] a, input logic [7:0] b,
                           output logic [7:0] d, output logic bo, output logic z,
                           output int lat, output int waited, output logic bsy);
        waited = 0;
        while (ready8 !== 1'b1 && waited < 50) begin
            @(posedge clk); #1; waited++;
        end
        @(negedge clk);
        start8 = 1'b1; a8 = a; b8 = b;
        @(posedge clk); #1;
        bsy = busy8;
        start8 = 1'b0; a8 = 8'hA5; b8 = 8'h5A;
        lat = -1; d = 8'h00; bo = 1'b0; z = 1'b0;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk); #1;
            if (done8 === 1'b1) begin
                lat = e; d = diff8; bo = bout8; z = zero8;
                break;
            end
        end
    endtask

    task automatic run_op4(input logic [3:0] a, input logic [3:0] b,
                           output logic [3:0] d, output logic bo, output logic z,
                           output int lat);
        int g;
        g = 0;
        while (ready4 !== 1'b1 && g < 50) begin
            @(posedge clk); #1; g++;
        end
        @(negedge clk);
        start4 = 1'b1; a4 = a; b4 = b;
        @(posedge clk); #1;
        start4 = 1'b0; a4 = 4'hF; b4 = 4'h0;
        lat = -1; d = 4'h0; bo = 1'b0; z = 1'b0;
        for (int e = 1; e <= 30; e++) begin
            @(posedge clk); #1;
            if (done4 === 1'b1) begin
                lat = e; d = diff4; bo = bout4; z = zero4;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start8 = 1'b0; start4 = 1'b0;
        a8 = 8'h00; b8 = 8'h00; a4 = 4'h0; b4 = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({ready8, busy8, done8, bout8, zero8} !== 5'b10000) begin
            bad++; $display("FAIL reset_flags8: got %b expected 10000", {ready8, busy8, done8, bout8, zero8});
        end
        total++;
        if (diff8 !== 8'h00) begin
            bad++; $display("FAIL reset_diff8: got %h expected 00", diff8);
        end
        total++;
        if ({ready4, busy4, done4, bout4, zero4, diff4} !== 9'b100000000) begin
            bad++; $display("FAIL reset_w4: got %b expected 100000000", {ready4, busy4, done4, bout4, zero4, diff4});
        end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_arith();
        logic [7:0] va[5]  = '{8'd200, 8'd55,  8'h00, 8'hFF, 8'h00};
        logic [7:0] vb[5]  = '{8'd55,  8'd200, 8'h00, 8'hFF, 8'h01};
        logic [7:0] vd[5]  = '{8'h91,  8'h6F,  8'h00, 8'h00, 8'hFF};
        logic       vbo[5] = '{1'b0,   1'b1,   1'b0,  1'b0,  1'b1};
        logic       vz[5]  = '{1'b0,   1'b0,   1'b1,  1'b1,  1'b0};
        logic [7:0] d;
        logic       bo, z, bsy;
        int         lat, w;
        for (int i = 0; i < 5; i++) begin
            run_op8(va[i], vb[i], d, bo, z, lat, w, bsy);
            total++;
            if (bsy !== 1'b1) begin
                bad++; $display("FAIL arith%0d_busy: got %b expected 1", i, bsy);
            end
            total++;
            if (lat !== 8) begin
                bad++; $display("FAIL arith%0d_latency: got %0d expected 8", i, lat);
            end
            total++;
            if (d !== vd[i]) begin
                bad++; $display("FAIL arith%0d_diff: got %h expected %h", i, d, vd[i]);
            end
            total++;
            if ({bo, z} !== {vbo[i], vz[i]}) begin
                bad++; $display("FAIL arith%0d_flags: got %b expected %b", i, {bo, z}, {vbo[i], vz[i]});
            end
        end
        // Result must stay visible once back in IDLE.
        @(posedge clk); #1;
        total++;
        if ({ready8, diff8, bout8} !== {1'b1, 8'hFF, 1'b1}) begin
            bad++; $display("FAIL hold_idle: got %b expected %b", {ready8, diff8, bout8}, {1'b1, 8'hFF, 1'b1});
        end
    endtask

    task automatic test_ignored_start();
        int         ndone;
        logic [7:0] cap;
        logic       capbo;
        ndone = 0; cap = 8'h00; capbo = 1'b1;
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h10; b8 = 8'h03;
        @(posedge clk); #1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            start8 = (k == 3 || k == 9) ? 1'b1 : 1'b0;
            a8 = 8'hFF; b8 = 8'h00;
            @(posedge clk); #1;
            if (done8 === 1'b1) begin
                ndone++; cap = diff8; capbo = bout8;
            end
            if (k == 3) begin
                total++;
                if ({ready8, busy8} !== 2'b01) begin
                    bad++; $display("FAIL ignore_busy: got %b expected 01", {ready8, busy8});
                end
            end
        end
        start8 = 1'b0;
        total++;
        if (ndone !== 1) begin
            bad++; $display("FAIL ignore_done_count: got %0d expected 1", ndone);
        end
        total++;
        if ({cap, capbo} !== {8'h0D, 1'b0}) begin
            bad++; $display("FAIL ignore_result: got %h/%b expected 0d/0", cap, capbo);
        end
        total++;
        if ({ready8, busy8} !== 2'b10) begin
            bad++; $display("FAIL ignore_not_queued: got %b expected 10", {ready8, busy8});
        end
    endtask

    task automatic test_reset_mid_run();
        logic [7:0] d;
        logic       bo, z, bsy;
        int         lat, w, ndone;
        run_op8(8'h00, 8'h01, d, bo, z, lat, w, bsy);
        total++;
        if ({d, bo} !== {8'hFF, 1'b1}) begin
            bad++; $display("FAIL pre_reset_op: got %h/%b expected ff/1", d, bo);
        end
        @(posedge clk); #1;
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h05; b8 = 8'h09;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1; start8 = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({ready8, busy8, done8, bout8, zero8, diff8} !== 13'b1000000000000) begin
            bad++; $display("FAIL midrun_reset: got %b expected 1000000000000", {ready8, busy8, done8, bout8, zero8, diff8});
        end
        @(negedge clk);
        rst = 1'b0; start8 = 1'b0;
        ndone = 0;
        for (int k = 0; k < 11; k++) begin
            @(posedge clk); #1;
            if (done8 === 1'b1 || ready8 !== 1'b1) ndone++;
        end
        total++;
        if (ndone !== 0) begin
            bad++; $display("FAIL midrun_no_done: got %0d bad cycles expected 0", ndone);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        logic       bo, z, bsy;
        int         lat, w;
        run_op8(8'h80, 8'h7F, d, bo, z, lat, w, bsy);
        total++;
        if ({d, bo, z} !== {8'h01, 1'b0, 1'b0}) begin
            bad++; $display("FAIL b2b_first: got %h/%b/%b expected 01/0/0", d, bo, z);
        end
        run_op8(8'h3C, 8'hC3, d, bo, z, lat, w, bsy);
        total++;
        if (w !== 1) begin
            bad++; $display("FAIL b2b_spacing: got %0d wait edges expected 1", w);
        end
        total++;
        if ({d, bo, z, lat} !== {8'h79, 1'b1, 1'b0, 8}) begin
            bad++; $display("FAIL b2b_second: got %h/%b/%b lat %0d expected 79/1/0 lat 8", d, bo, z, lat);
        end
    endtask

    task automatic test_w4_exhaustive();
        logic [3:0] d, ea, eb, ed;
        logic       bo, z;
        int         lat;
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                ea = i[3:0]; eb = j[3:0];
                ed = (i - j) & 15;
                run_op4(ea, eb, d, bo, z, lat);
                total++;
                if ({d, bo, z, lat} !== {ed, (i < j), (i == j), 4}) begin
                    bad++;
                    $display("FAIL w4_%0d_%0d: got %h/%b/%b lat %0d expected %h/%b/%b lat 4",
                             i, j, d, bo, z, lat, ed, (i < j), (i == j));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_ignored_start();
        test_reset_mid_run();
        test_back_to_back();
        test_w4_exhaustive();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
